// File: rtl/temp_entry_sequencer_pkg.sv
// Shared encodings for the temperature entry sequencer.
package temp_entry_sequencer_pkg;

  typedef enum logic [2:0] {
    ENTER_ONES = 3'd0,
    ENTER_TENS = 3'd1,
    ENTER_HUNS = 3'd2,
    COMMIT     = 3'd3,
    SHOW       = 3'd4
  } seq_state_t;

  localparam logic [1:0] ENTRY_DONE = 2'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  // Digit position shown to the datapath for a given state.
  function automatic logic [1:0] entry_index(input seq_state_t s);
    case (s)
      ENTER_ONES: return 2'd0;
      ENTER_TENS: return 2'd1;
      ENTER_HUNS: return 2'd2;
      default:    return ENTRY_DONE;
    endcase
  endfunction

endpackage

// File: rtl/temp_entry_sequencer_key_debounce.sv
// Entry key debouncer: 2-flop synchronizer, stability counter, accepted
// level and a one-cycle pulse on an accepted press (1->0) edge.
module temp_entry_sequencer_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DBC_W           = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam logic [DBC_W-1:0] CNT_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             level;
  logic             level_d;
  logic [DBC_W-1:0] cnt;

  // Bring the raw key into the clk domain; idle level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= key_n;
      sync_2 <= sync_1;
    end
  end

  // Count how long the synchronized key has disagreed with the accepted
  // level; adopt it once it has held for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b1;
    end else if (sync_2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync_2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered falling-edge detect on the accepted level; releases are silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level_d & ~level;
    end
  end

endmodule

// File: rtl/temp_entry_sequencer.sv
// Temperature entry sequencer: BCD digit entry, reading handoff to the
// subtractor path, and the display rotation shown between entries.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   ENTER_ONES | waiting for the ones digit
//   ENTER_TENS | waiting for the tens digit
//   ENTER_HUNS | waiting for the hundreds digit and sign
//   COMMIT     | rd_valid high until rd_ready completes the handoff
//   SHOW       | rotating display phases until the next press
module temp_entry_sequencer
  import temp_entry_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DBC_W           = 19
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_n,
  input  logic [3:0]  bcd_num,
  input  logic        sign_on,
  input  logic        disp_tick,
  input  logic        rd_ready,
  output logic        rd_valid,
  output logic [1:0]  entry_idx,
  output logic [11:0] ent_bcd,
  output logic [11:0] cur_bcd,
  output logic        cur_neg,
  output logic [11:0] prev_bcd,
  output logic        prev_neg,
  output logic        first_reading,
  output logic        digit_err,
  output logic [1:0]  disp_phase
);

  logic       press;
  seq_state_t state, state_nx;
  logic       sign_stg, sign_stg_nx;
  logic [11:0] ent_nx, cur_nx, prev_nx;
  logic       cur_neg_nx, prev_neg_nx, first_nx, err_nx;
  logic [1:0] phase_nx;
  logic       digit_bad;

  temp_entry_sequencer_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DBC_W          (DBC_W)
  ) u_key_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .press(press)
  );

  assign digit_bad = (bcd_num > BCD_MAX);

  // Next-state and next-data decode; every register holds by default.
  always_comb begin
    state_nx    = state;
    ent_nx      = ent_bcd;
    sign_stg_nx = sign_stg;
    cur_nx      = cur_bcd;
    cur_neg_nx  = cur_neg;
    prev_nx     = prev_bcd;
    prev_neg_nx = prev_neg;
    first_nx    = first_reading;
    err_nx      = 1'b0;
    phase_nx    = disp_phase;
    case (state)
      ENTER_ONES: begin
        if (press) begin
          if (digit_bad) begin
            err_nx = 1'b1;
          end else begin
            ent_nx[3:0] = bcd_num;
            state_nx    = ENTER_TENS;
          end
        end
      end
      ENTER_TENS: begin
        if (press) begin
          if (digit_bad) begin
            err_nx = 1'b1;
          end else begin
            ent_nx[7:4] = bcd_num;
            state_nx    = ENTER_HUNS;
          end
        end
      end
      ENTER_HUNS: begin
        if (press) begin
          if (digit_bad) begin
            err_nx = 1'b1;
          end else begin
            ent_nx[11:8] = bcd_num;
            sign_stg_nx  = sign_on;
            state_nx     = COMMIT;
          end
        end
      end
      COMMIT: begin
        // rd_valid is high throughout COMMIT, so rd_ready alone completes it.
        if (rd_ready) begin
          prev_nx     = cur_bcd;
          prev_neg_nx = cur_neg;
          cur_nx      = ent_bcd;
          cur_neg_nx  = sign_stg;
          first_nx    = 1'b0;
          state_nx    = SHOW;
        end
      end
      SHOW: begin
        if (press) begin
          ent_nx   = '0;
          phase_nx = 2'd0;
          state_nx = ENTER_ONES;
        end else if (disp_tick) begin
          phase_nx = disp_phase + 2'd1;
        end
      end
      default: state_nx = ENTER_ONES;
    endcase
  end

  // State and data registers; rd_valid and entry_idx are registered from
  // the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ENTER_ONES;
      ent_bcd       <= '0;
      sign_stg      <= 1'b0;
      cur_bcd       <= '0;
      cur_neg       <= 1'b0;
      prev_bcd      <= '0;
      prev_neg      <= 1'b0;
      first_reading <= 1'b1;
      digit_err     <= 1'b0;
      disp_phase    <= 2'd0;
      rd_valid      <= 1'b0;
      entry_idx     <= 2'd0;
    end else begin
      state         <= state_nx;
      ent_bcd       <= ent_nx;
      sign_stg      <= sign_stg_nx;
      cur_bcd       <= cur_nx;
      cur_neg       <= cur_neg_nx;
      prev_bcd      <= prev_nx;
      prev_neg      <= prev_neg_nx;
      first_reading <= first_nx;
      digit_err     <= err_nx;
      disp_phase    <= phase_nx;
      rd_valid      <= (state_nx == COMMIT);
      entry_idx     <= entry_index(state_nx);
    end
  end

endmodule

// File: tb/tb_temp_entry_sequencer.sv
// Directed bench for temp_entry_sequencer with a small debounce window.
module tb_temp_entry_sequencer;

  localparam int DBC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_n;
  logic [3:0]  bcd_num;
  logic        sign_on;
  logic        disp_tick;
  logic        rd_ready;
  logic        rd_valid;
  logic [1:0]  entry_idx;
  logic [11:0] ent_bcd;
  logic [11:0] cur_bcd;
  logic        cur_neg;
  logic [11:0] prev_bcd;
  logic        prev_neg;
  logic        first_reading;
  logic        digit_err;
  logic [1:0]  disp_phase;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  temp_entry_sequencer #(.DEBOUNCE_CYCLES(DBC), .DBC_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_n        (key_n),
    .bcd_num      (bcd_num),
    .sign_on      (sign_on),
    .disp_tick    (disp_tick),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .entry_idx    (entry_idx),
    .ent_bcd      (ent_bcd),
    .cur_bcd      (cur_bcd),
    .cur_neg      (cur_neg),
    .prev_bcd     (prev_bcd),
    .prev_neg     (prev_neg),
    .first_reading(first_reading),
    .digit_err    (digit_err),
    .disp_phase   (disp_phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [15:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic got(input logic [15:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %0h required nothing", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        miscompares++;
        $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.v);
      end
    end
  endtask

  // Hold the key low long enough to be accepted, then release it.
  // The press reaches the FSM on the 8th edge after key_n falls.
  task automatic press(input logic [3:0] d, input logic s, input bit coincide,
                       output logic err_at, output logic err_after);
    bcd_num = d;
    sign_on = s;
    key_n   = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    if (coincide) disp_tick = 1'b1;
    tick();
    err_at    = digit_err;
    disp_tick = 1'b0;
    tick();
    err_after = digit_err;
    key_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic handshake();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    tick();
  endtask

  logic ea, eb;

  initial begin
    rst_n = 1'b0; key_n = 1'b1; bcd_num = 4'd0; sign_on = 1'b0;
    disp_tick = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    expect_v("rst_idx", 16'd0);   expect_v("rst_valid", 16'd0);
    expect_v("rst_first", 16'd1); expect_v("rst_cur", 16'h000);
    expect_v("rst_prev", 16'h000); expect_v("rst_ent", 16'h000);
    expect_v("rst_phase", 16'd0);
    got(entry_idx); got(rd_valid); got(first_reading); got(cur_bcd);
    got(prev_bcd); got(ent_bcd); got(disp_phase);

    // Short glitch on the key plus rd_ready while nothing is valid
    expect_v("glitch_idx", 16'd0); expect_v("glitch_ent", 16'h000);
    expect_v("idle_ready_first", 16'd1); expect_v("idle_ready_cur", 16'h000);
    bcd_num = 4'd7; key_n = 1'b0; rd_ready = 1'b1;
    tick(); tick();
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    rd_ready = 1'b0;
    got(entry_idx); got(ent_bcd); got(first_reading); got(cur_bcd);

    // Ones digit 5
    expect_v("ones_idx", 16'd1); expect_v("ones_ent", 16'h005);
    press(4'd5, 1'b0, 1'b0, ea, eb);
    got(entry_idx); got(ent_bcd);

    // Illegal digit in ENTER_TENS
    expect_v("err_pulse", 16'd1); expect_v("err_clear", 16'd0);
    expect_v("err_idx", 16'd1); expect_v("err_ent", 16'h005);
    press(4'hB, 1'b0, 1'b0, ea, eb);
    got(ea); got(eb); got(entry_idx); got(ent_bcd);

    // Tens 2, hundreds 1 negative
    expect_v("tens_idx", 16'd2); expect_v("tens_ent", 16'h025);
    press(4'd2, 1'b0, 1'b0, ea, eb);
    got(entry_idx); got(ent_bcd);
    expect_v("huns_idx", 16'd3); expect_v("huns_ent", 16'h125);
    expect_v("commit_valid", 16'd1);
    press(4'd1, 1'b1, 1'b0, ea, eb);
    got(entry_idx); got(ent_bcd); got(rd_valid);

    // rd_valid held without rd_ready; subtractor inputs untouched
    expect_v("hold_valid", 16'd1); expect_v("hold_cur", 16'h000);
    for (int i = 0; i < 6; i++) tick();
    got(rd_valid); got(cur_bcd);

    // First handshake
    expect_v("hs1_cur", 16'h125); expect_v("hs1_neg", 16'd1);
    expect_v("hs1_prev", 16'h000); expect_v("hs1_first", 16'd0);
    expect_v("hs1_valid", 16'd0); expect_v("hs1_idx", 16'd3);
    handshake();
    got(cur_bcd); got(cur_neg); got(prev_bcd); got(first_reading);
    got(rd_valid); got(entry_idx);

    // Display rotation: five ticks
    for (int i = 0; i < 5; i++) begin
      expect_v($sformatf("phase_%0d", i), 16'((i + 1) % 4));
      disp_tick = 1'b1;
      tick();
      disp_tick = 1'b0;
      tick();
      got(disp_phase);
    end

    // Leave SHOW and enter 0x090, positive
    expect_v("show_exit_idx", 16'd0); expect_v("show_exit_phase", 16'd0);
    expect_v("show_exit_ent", 16'h000);
    press(4'd0, 1'b0, 1'b0, ea, eb);
    got(entry_idx); got(disp_phase); got(ent_bcd);
    press(4'd0, 1'b0, 1'b0, ea, eb);
    press(4'd9, 1'b0, 1'b0, ea, eb);
    press(4'd0, 1'b0, 1'b0, ea, eb);
    expect_v("hs2_prev", 16'h125); expect_v("hs2_prev_neg", 16'd1);
    expect_v("hs2_cur", 16'h090); expect_v("hs2_neg", 16'd0);
    handshake();
    got(prev_bcd); got(prev_neg); got(cur_bcd); got(cur_neg);

    // Reset in the middle of ENTER_HUNS
    press(4'd0, 1'b0, 1'b0, ea, eb);
    press(4'd3, 1'b0, 1'b0, ea, eb);
    press(4'd4, 1'b0, 1'b0, ea, eb);
    expect_v("mid_idx", 16'd2);
    got(entry_idx);
    expect_v("arst_idx", 16'd0); expect_v("arst_ent", 16'h000);
    expect_v("arst_cur", 16'h000); expect_v("arst_first", 16'd1);
    expect_v("arst_prev", 16'h000);
    rst_n = 1'b0;
    #2;
    got(entry_idx); got(ent_bcd); got(cur_bcd); got(first_reading); got(prev_bcd);
    tick();
    rst_n = 1'b1;
    tick();

    // Press during COMMIT is ignored
    press(4'd1, 1'b0, 1'b0, ea, eb);
    press(4'd2, 1'b0, 1'b0, ea, eb);
    press(4'd3, 1'b1, 1'b0, ea, eb);
    expect_v("commit_press_idx", 16'd3); expect_v("commit_press_ent", 16'h321);
    expect_v("commit_press_valid", 16'd1);
    press(4'd7, 1'b0, 1'b0, ea, eb);
    got(entry_idx); got(ent_bcd); got(rd_valid);
    expect_v("hs3_cur", 16'h321); expect_v("hs3_neg", 16'd1);
    handshake();
    got(cur_bcd); got(cur_neg);

    // Press coincident with disp_tick in SHOW
    expect_v("pre_phase", 16'd1);
    disp_tick = 1'b1; tick(); disp_tick = 1'b0; tick();
    got(disp_phase);
    expect_v("coinc_idx", 16'd0); expect_v("coinc_phase", 16'd0);
    press(4'd6, 1'b0, 1'b1, ea, eb);
    got(entry_idx); got(disp_phase);

    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
